// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings, FSM states, helpers.
// Build option: MULDIV_ACCUM_EN enables the MADD/MADDU/MSUB/MSUBU accumulate ops (4-7).
package muldiv_pkg;

    localparam int DEFAULT_WIDTH = 32;

`ifdef MULDIV_ACCUM_EN
    localparam bit ACCUM_EN = 1'b1;
`else
    localparam bit ACCUM_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MADD  = 3'd4,
        OP_MADDU = 3'd5,
        OP_MSUB  = 3'd6,
        OP_MSUBU = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic logic op_valid(input logic [2:0] op);
        return !op[2] || ACCUM_EN;
    endfunction

    // Even encodings (MULT, DIV, MADD, MSUB) are the signed flavours.
    function automatic logic op_signed(input logic [2:0] op);
        return !op[0];
    endfunction

    function automatic logic op_div(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_accum(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic op_sub(input logic [2:0] op);
        return (op == OP_MSUB) || (op == OP_MSUBU);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Pipeline-to-MDU bundle: launch/cancel/operands toward the unit, status and HI/LO write back.
interface muldiv_if import muldiv_pkg::*; #(parameter int WIDTH = DEFAULT_WIDTH);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic [WIDTH-1:0] hi_i;
    logic [WIDTH-1:0] lo_i;
    logic             cancel;
    logic             busy;
    logic             done;
    logic             hilo_we;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (output start, op, a_i, b_i, hi_i, lo_i, cancel,
                    input  busy, done, hilo_we, hi_o, lo_o);
    modport slave  (input  start, op, a_i, b_i, hi_i, lo_i, cancel,
                    output busy, done, hilo_we, hi_o, lo_o);
endinterface

// File: rtl/muldiv_divstep.sv
// One restoring-division iteration: shifted partial remainder minus divisor, keep or restore.
module muldiv_divstep #(parameter int WIDTH = 32) (
    input  logic [WIDTH:0]   partial,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);
    logic [WIDTH+1:0] diff;

    assign diff = {1'b0, partial} - {2'b0, divisor};
    // partial < 2*divisor holds every step, so a non-negative difference always fits WIDTH bits.
    assign q_bit    = ~|diff[WIDTH+1:WIDTH];
    assign rem_next = q_bit ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit feeding HI/LO; WIDTH-cycle CALC, one FIX cycle, one DONE cycle.
// Build option: MULDIV_ACCUM_EN adds MADD/MADDU/MSUB/MSUBU accumulating into sampled {hi_i, lo_i}.
module muldiv_unit import muldiv_pkg::*; #(parameter int WIDTH = DEFAULT_WIDTH) (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e             state, state_next;
    op_e                op_q;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   a_mag, b_mag, a_raw;
    logic               neg_res, neg_rem, div0;
    logic [WIDTH-1:0]   hi_q, lo_q;
`ifdef MULDIV_ACCUM_EN
    logic [2*WIDTH-1:0] acc_q;
`endif

    logic               accept, a_neg, b_neg;
    logic [WIDTH-1:0]   a_in_mag, b_in_mag;

    assign accept   = (state == IDLE) && bus.start && !bus.cancel && op_valid(bus.op);
    assign a_neg    = op_signed(bus.op) && bus.a_i[WIDTH-1];
    assign b_neg    = op_signed(bus.op) && bus.b_i[WIDTH-1];
    assign a_in_mag = a_neg ? -bus.a_i : bus.a_i;
    assign b_in_mag = b_neg ? -bus.b_i : bus.b_i;

    // Shift-add: {upper, lower} holds partial product above the not-yet-consumed multiplier bits.
    logic [WIDTH:0]     upper_sum;
    logic [2*WIDTH-1:0] mul_next, div_next;
    logic [WIDTH-1:0]   rem_next;
    logic               q_bit;

    assign upper_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (prod[0] ? a_mag : '0)};
    assign mul_next  = {upper_sum, prod[WIDTH-1:1]};
    assign div_next  = {rem_next, prod[WIDTH-2:0], q_bit};

    muldiv_divstep #(.WIDTH(WIDTH)) u_divstep (
        .partial  ({prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]}),
        .divisor  (b_mag),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    logic [2*WIDTH-1:0] prod_signed, mul_res, fix_res;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    // NOTE: every always_comb output gets a default first so no path can leave it unassigned (no latch).
    always_comb begin
        prod_signed = neg_res ? -prod : prod;
        mul_res     = prod_signed;
`ifdef MULDIV_ACCUM_EN
        if (op_accum(op_q))
            mul_res = op_sub(op_q) ? acc_q - prod_signed : acc_q + prod_signed;
`endif
        quot_fix = neg_res ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
        rem_fix  = neg_rem ? -prod[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];
        if (!op_div(op_q))
            fix_res = mul_res;
        else if (div0)
            fix_res = {a_raw, {WIDTH{1'b1}}};
        else
            fix_res = {rem_fix, quot_fix};
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (accept) state_next = CALC;
            CALC: if (bus.cancel) state_next = IDLE;
                  else if (count == CW'(WIDTH - 1)) state_next = FIX;
            FIX:  state_next = bus.cancel ? IDLE : DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            state <= state_next;
            if (state == FIX && state_next == DONE)
                {hi_q, lo_q} <= fix_res;
        end
    end

    // NOTE: datapath registers carry no reset; they are always reloaded at accept before being read.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q    <= op_e'(bus.op);
            count   <= '0;
            a_mag   <= a_in_mag;
            b_mag   <= b_in_mag;
            a_raw   <= bus.a_i;
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            div0    <= (bus.b_i == '0);
            prod    <= op_div(bus.op) ? {{WIDTH{1'b0}}, a_in_mag} : {{WIDTH{1'b0}}, b_in_mag};
`ifdef MULDIV_ACCUM_EN
            acc_q   <= {bus.hi_i, bus.lo_i};
`endif
        end else if (state == CALC) begin
            count <= count + 1'b1;
            prod  <= op_div(op_q) ? div_next : mul_next;
        end
    end

    assign bus.busy    = (state != IDLE);
    assign bus.done    = (state == DONE);
    assign bus.hilo_we = (state == DONE);
    assign bus.hi_o    = hi_q;
    assign bus.lo_o    = lo_q;
endmodule
